// File: rtl/ps2_mouse_rx_if.sv
// PS/2 mouse receiver bus: raw PS/2 lines in, paddle direction/speed and status out.
interface ps2_mouse_rx_if #(
  parameter int unsigned SPEED_W = 8
);
  logic               ps2_clk;
  logic               ps2_data;
  logic               paddle_dir;
  logic [SPEED_W-1:0] paddle_speed;
  logic               error_flag;
  logic               new_output_flag;

  modport master (
    output ps2_clk, ps2_data,
    input  paddle_dir, paddle_speed, error_flag, new_output_flag
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output paddle_dir, paddle_speed, error_flag, new_output_flag
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver producing a saturated paddle direction/speed pair.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_mouse_rx #(
  parameter int unsigned PACKET_BYTES = 3,
  parameter int unsigned AXIS         = 1,
  parameter int unsigned SPEED_W      = 8,
  parameter int unsigned SPEED_SHIFT  = 0,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC  = 50000
) (
  input logic           clk_25MHz,
  input logic           reset,
  ps2_mouse_rx_if.slave bus
);

  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [1:0] LAST_IDX = 2'(PACKET_BYTES - 1);
  localparam logic [1:0] AXIS_IDX = (AXIS == 0) ? 2'd1 : 2'd2;
  localparam logic [9:0] SPD_MAX  = 10'((1 << SPEED_W) - 1);

  // Line conditioning: index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]       sync1_q, sync2_q, filt_q, filt_d;
  logic [FLT_W-1:0] fcnt_q [2];
  logic [FLT_W-1:0] fcnt_d [2];
  logic             clk_prev_q;

  logic [1:0]         state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         hdr_q, hdr_d;
  logic [7:0]         axis_q, axis_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               dir_q, dir_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               err_q, err_d;
  logic               pulse_q, pulse_d;
`ifdef PS2_PARITY_CHECK_EN
  logic               par_q, par_d;
`endif

  logic       bit_ev_c, data_c, abort_c, word_done_c, sign_c, ovf_c;
  logic [7:0] axis_byte_c;
  logic [8:0] delta_c, mag_c;
  logic [9:0] shr_c, speed_c;

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      hdr_q      <= '0;
      axis_q     <= '0;
      wd_q       <= '0;
      dir_q      <= 1'b0;
      speed_q    <= '0;
      err_q      <= 1'b0;
      pulse_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      sync1_q    <= {bus.ps2_data, bus.ps2_clk};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      fcnt_q[0]  <= fcnt_d[0];
      fcnt_q[1]  <= fcnt_d[1];
      clk_prev_q <= filt_q[0];
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      hdr_q      <= hdr_d;
      axis_q     <= axis_d;
      wd_q       <= wd_d;
      dir_q      <= dir_d;
      speed_q    <= speed_d;
      err_q      <= err_d;
      pulse_q    <= pulse_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  // Stability filter: a line must disagree for FILTER_LEN cycles before it is accepted
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLT_W'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else fcnt_d[i] = FLT_W'(fcnt_q[i] + 1'b1);
      end
    end
  end

  // Paddle arithmetic from the stored header and the selected axis byte
  always_comb begin
    sign_c      = (AXIS == 0) ? hdr_q[0] : hdr_q[1];
    ovf_c       = (AXIS == 0) ? hdr_q[2] : hdr_q[3];
    axis_byte_c = (AXIS_IDX == LAST_IDX) ? shift_q : axis_q;
    delta_c     = {sign_c, axis_byte_c};
    mag_c       = sign_c ? 9'(~delta_c + 9'd1) : delta_c;
    shr_c       = {1'b0, mag_c} >> SPEED_SHIFT;
    speed_c     = (ovf_c || (shr_c > SPD_MAX)) ? SPD_MAX : shr_c;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    hdr_d       = hdr_q;
    axis_d      = axis_q;
    wd_d        = wd_q;
    dir_d       = dir_q;
    speed_d     = speed_q;
    err_d       = err_q;
    pulse_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif
    abort_c     = 1'b0;
    word_done_c = 1'b0;
    bit_ev_c    = clk_prev_q & ~filt_q[0];
    data_c      = filt_q[1];

    if (bit_ev_c) begin
      wd_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_c) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            abort_c = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {data_c, shift_q[7:1]};
          bit_cnt_d = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = data_c;
`endif
          state_d = STOP;
        end
        default: begin
          if (!data_c) abort_c = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          else if (!(^{par_q, shift_q})) abort_c = 1'b1;
`endif
          else if ((idx_q == 2'd0) && !shift_q[3]) abort_c = 1'b1;
          else word_done_c = 1'b1;
        end
      endcase
    end else if ((state_q != IDLE) || (idx_q != 2'd0)) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) abort_c = 1'b1;
      else wd_d = WD_W'(wd_q + 1'b1);
    end

    if (word_done_c) begin
      state_d = IDLE;
      if (idx_q == 2'd0) hdr_d = shift_q[7:4];
      if (idx_q == AXIS_IDX) axis_d = shift_q;
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        pulse_d = 1'b1;
        err_d   = 1'b0;
        dir_d   = sign_c;
        speed_d = SPEED_W'(speed_c);
      end else begin
        idx_d = 2'(idx_q + 2'd1);
      end
    end

    if (abort_c) begin
      state_d = IDLE;
      idx_d   = '0;
      wd_d    = '0;
      err_d   = 1'b1;
    end
  end

  assign bus.paddle_dir      = dir_q;
  assign bus.paddle_speed    = speed_q;
  assign bus.error_flag      = err_q;
  assign bus.new_output_flag = pulse_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Randomised bench for ps2_mouse_rx against an arithmetic packet model.
module tb_ps2_mouse_rx;
  localparam int unsigned PB   = 3;
  localparam int unsigned AX   = 1;
  localparam int unsigned SW   = 6;
  localparam int unsigned SH   = 0;
  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 10;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_mouse_rx_if #(.SPEED_W(SW)) bus ();

  ps2_mouse_rx #(
    .PACKET_BYTES(PB), .AXIS(AX), .SPEED_W(SW), .SPEED_SHIFT(SH),
    .FILTER_LEN(FL), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_25MHz(clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int wide     = 0;
  logic pulse_prev = 1'b0;

  int exp_dir   = 0;
  int exp_speed = 0;
  int exp_err   = 0;

  always @(negedge clk) begin
    if (bus.new_output_flag) begin
      pulses <= pulses + 1;
      if (pulse_prev) wide <= wide + 1;
    end
    pulse_prev <= bus.new_output_flag;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    idle(HALF);
    bus.ps2_clk = 1'b0;
    idle(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  // Frame: start 0, data LSB first, odd parity (optionally corrupted), stop 1
  task automatic send_word(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    logic par;
    par = ~(^b) ^ bad_par;
    fr  = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    bus.ps2_data = 1'b1;
    idle(2 * HALF);
  endtask

  // Reference: signed axis delta, magnitude, shift, saturation, overflow override
  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int sel, d, m, mx;
    bit sgn, ov;
    sel = (AX != 0) ? int'(b2) : int'(b1);
    sgn = (AX != 0) ? b0[5] : b0[4];
    ov  = (AX != 0) ? b0[7] : b0[6];
    d   = sgn ? sel - 256 : sel;
    m   = (d < 0) ? -d : d;
    m   = m >>> SH;
    mx  = (1 << SW) - 1;
    if (m > mx || ov) m = mx;
    exp_dir   = int'(sgn);
    exp_speed = m;
    exp_err   = 0;
  endtask

  task automatic run_check(input string tag, input int p0, input int exp_np);
    for (int i = 0; i < 80 && pulses == p0 && exp_np > 0; i++) @(negedge clk);
    if (exp_np == 0) idle(80);
    idle(5);
    @(negedge clk);
    check({tag, "_pulse"}, pulses - p0, exp_np);
    check({tag, "_dir"}, int'(bus.paddle_dir), exp_dir);
    check({tag, "_speed"}, int'(bus.paddle_speed), exp_speed);
    check({tag, "_err"}, int'(bus.error_flag), exp_err);
  endtask

  task automatic good_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int p0;
    p0 = pulses;
    send_word(b0, 1'b0, 11);
    send_word(b1, 1'b0, 11);
    send_word(b2, 1'b0, 11);
    model_packet(b0, b1, b2);
    run_check(tag, p0, 1);
  endtask

  task automatic parity_case(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int p0;
    p0 = pulses;
    send_word(b0, 1'b0, 11);
    send_word(b1, 1'b1, 11);
    if (PAR_EN) begin
      exp_err = 1;
      run_check(tag, p0, 0);
    end else begin
      send_word(b2, 1'b0, 11);
      model_packet(b0, b1, b2);
      run_check(tag, p0, 1);
    end
  endtask

  task automatic sync_case(input string tag, input logic [7:0] b0);
    int p0;
    p0 = pulses;
    send_word(b0, 1'b0, 11);
    exp_err = 1;
    run_check(tag, p0, 0);
  endtask

  initial begin
    int p0;
    logic [7:0] r0, r1, r2;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    idle(5);
    @(negedge clk);
    rst = 1'b0;

    p0 = pulses;
    idle(1000);
    run_check("reset_idle", p0, 0);

    good_packet("pkt_28_05_f6", 8'h28, 8'h05, 8'hF6);
    check("pkt_28_speed_const", int'(bus.paddle_speed), 10);
    good_packet("pkt_ovf", 8'hA8, 8'h00, 8'h80);
    check("pkt_ovf_speed_const", int'(bus.paddle_speed), (1 << SW) - 1);

    sync_case("sync_err", 8'h20);
    good_packet("after_sync", 8'h08, 8'h00, 8'h03);
    check("after_sync_speed_const", int'(bus.paddle_speed), 3);

    // Stall mid-word in byte 1 until the watchdog expires
    p0 = pulses;
    send_word(8'h18, 1'b0, 11);
    send_word(8'h35, 1'b0, 6);
    idle(TO + 200);
    exp_err = 1;
    run_check("timeout", p0, 0);
    good_packet("after_timeout", 8'h38, 8'h12, 8'h21);

    parity_case("parity", 8'h18, 8'h07, 8'h09);
    good_packet("after_parity", 8'h08, 8'h40, 8'h7F);

    // Reset mid-packet discards the partial packet and clears outputs
    p0 = pulses;
    send_word(8'h28, 1'b0, 11);
    send_word(8'h11, 1'b0, 11);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    exp_dir = 0;
    exp_speed = 0;
    exp_err = 0;
    check("rst_mid_dir", int'(bus.paddle_dir), 0);
    check("rst_mid_speed", int'(bus.paddle_speed), 0);
    rst = 1'b0;
    run_check("rst_mid", p0, 0);

    for (int k = 0; k < 25; k++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r0[3] = (kind == 2) ? 1'b0 : 1'b1;
      case (kind)
        2:       sync_case("rnd_sync", r0);
        3:       parity_case("rnd_parity", r0, r1, r2);
        default: good_packet("rnd_pkt", r0, r1, r2);
      endcase
    end

    check("pulse_width", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
